level_block_writer: RTL and testbench



---
 rtl/level_block_writer.sv | 167 ++++++++++++++++
 tb/tb_level_block_writer.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/level_block_writer.sv
// Single writer for the level tile map. It queues pixel-space destroy requests and,
// during vertical blanking, read-checks each target tile and clears it with a one-cycle write.
module level_block_writer #(
  parameter int         TILE_SHIFT = 4,
  parameter int         COLS       = 40,
  parameter int         ROWS       = 30,
  parameter int         DEPTH      = 4,
  parameter logic [2:0] MATCH_TYPE = 3'd4,
  parameter logic [2:0] CLEAR_TYPE = 3'd0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  input  logic [9:0]  req_x,
  input  logic [9:0]  req_y,
  output logic        req_ready,
  input  logic        vblank,
  output logic [9:0]  chk_x,
  output logic [9:0]  chk_y,
  input  logic [2:0]  chk_type,
  output logic        wr_en,
  output logic [10:0] wr_addr,
  output logic [2:0]  wr_data,
  output logic        destroyed,
  output logic        rejected,
  output logic [7:0]  destroy_count,
  output logic [1:0]  dbg_state_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, LOOKUP, DECIDE, WRITE} state_e;

  // Handshake: a request is taken on any rising clk edge where req_valid && req_ready;
  // req_ready depends only on FIFO occupancy (no bypass), and the requester holds
  // req_x/req_y stable while req_valid is high and req_ready is low.

  state_e          state_q, state_d;
  logic [19:0]     mem_q [DEPTH];
  logic [PW-1:0]   wptr_q, rptr_q;
  logic [PW:0]     count_q;
  logic [9:0]      chk_x_q, chk_x_d;
  logic [9:0]      chk_y_q, chk_y_d;
  logic [10:0]     addr_q, addr_d;
  logic [10:0]     wr_addr_q, wr_addr_d;
  logic [2:0]      wr_data_q, wr_data_d;
  logic [2:0]      tile_q, tile_d;
  logic            rej_q, rej_d;
  logic [7:0]      cnt_q, cnt_d;

  logic            full, empty, push, pop;
  logic [9:0]      head_x, head_y, head_col, head_row;
  logic            head_oor;
  logic [10:0]     head_addr;

  assign full      = (count_q == (PW+1)'(DEPTH));
  assign empty     = (count_q == '0);
  assign push      = req_valid && !full;
  assign req_ready = !full;

  assign head_x    = mem_q[rptr_q][9:0];
  assign head_y    = mem_q[rptr_q][19:10];
  assign head_col  = head_x >> TILE_SHIFT;
  assign head_row  = head_y >> TILE_SHIFT;
  assign head_oor  = (head_col >= 10'(COLS)) || (head_row >= 10'(ROWS));
  assign head_addr = 11'(head_row) * 11'(COLS) + 11'(head_col);

  always_comb begin
    state_d   = state_q;
    pop       = 1'b0;
    chk_x_d   = chk_x_q;
    chk_y_d   = chk_y_q;
    addr_d    = addr_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    tile_d    = tile_q;
    rej_d     = 1'b0;
    cnt_d     = cnt_q;
    case (state_q)
      IDLE: begin
        if (!empty && vblank) begin
          pop = 1'b1;
          if (head_oor) begin
            rej_d = 1'b1;
          end else begin
            chk_x_d = head_col << TILE_SHIFT;
            chk_y_d = head_row << TILE_SHIFT;
            addr_d  = head_addr;
            state_d = LOOKUP;
          end
        end
      end
      LOOKUP: begin
        tile_d  = chk_type;
        state_d = DECIDE;
      end
      DECIDE: begin
        // Address and data are loaded here so they are already valid in the WRITE cycle.
        if (tile_q == MATCH_TYPE) begin
          wr_addr_d = addr_q;
          wr_data_d = CLEAR_TYPE;
          state_d   = WRITE;
        end else begin
          state_d = IDLE;
        end
      end
      WRITE: begin
        if (cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr_q    <= '0;
      rptr_q    <= '0;
      count_q   <= '0;
      chk_x_q   <= '0;
      chk_y_q   <= '0;
      addr_q    <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      tile_q    <= '0;
      rej_q     <= 1'b0;
      cnt_q     <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      chk_x_q   <= chk_x_d;
      chk_y_q   <= chk_y_d;
      addr_q    <= addr_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      tile_q    <= tile_d;
      rej_q     <= rej_d;
      cnt_q     <= cnt_d;
    end
  end

  // Storage needs no reset: occupancy is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= {req_y, req_x};
  end

  assign chk_x         = chk_x_q;
  assign chk_y         = chk_y_q;
  assign wr_en         = (state_q == WRITE);
  assign destroyed     = (state_q == WRITE);
  assign wr_addr       = wr_addr_q;
  assign wr_data       = wr_data_q;
  assign rejected      = rej_q || ((state_q == DECIDE) && (tile_q != MATCH_TYPE));
  assign destroy_count = cnt_q;
  assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_level_block_writer.sv
// Bench for level_block_writer: a tile-map environment, a schedule-based reference model
// checked every cycle, and directed scenarios with hand-computed expectations.
module tb_level_block_writer;

  localparam int         DEPTH = 4;
  localparam logic [2:0] MATCH = 3'd4;
  localparam logic [2:0] CLEAR = 3'd0;

  logic        clk;
  logic        reset_n;
  logic        req_valid;
  logic [9:0]  req_x, req_y;
  logic        req_ready;
  logic        vblank;
  logic [9:0]  chk_x, chk_y;
  logic [2:0]  chk_type;
  logic        wr_en;
  logic [10:0] wr_addr;
  logic [2:0]  wr_data;
  logic        destroyed, rejected;
  logic [7:0]  destroy_count;
  logic [1:0]  dbg_state;

  level_block_writer dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_x(req_x), .req_y(req_y),
    .req_ready(req_ready), .vblank(vblank), .chk_x(chk_x), .chk_y(chk_y),
    .chk_type(chk_type), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .destroyed(destroyed), .rejected(rejected), .destroy_count(destroy_count),
    .dbg_state_o(dbg_state)
  );

  // clock / cycle counter
  initial clk = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // level map environment: initial contents plus tiles the DUT has cleared
  logic [2:0] init_map [1200];
  bit         cleared  [1200];
  always @(posedge clk) if (wr_en && wr_addr < 11'd1200) cleared[wr_addr] <= 1'b1;
  always_comb begin : level_read
    int li;
    li = int'(chk_y >> 4) * 40 + int'(chk_x >> 4);
    chk_type = 3'd0;
    if (li < 1200) chk_type = cleared[li] ? 3'd0 : init_map[li];
  end

  // reference model: request queue, per-cycle expected events, expected write addresses
  logic [19:0] req_q [$];
  logic [10:0] exp_q [$];
  bit          exp_wr [int];
  bit          exp_rej [int];
  bit          cnt_inc [int];
  logic [9:0]  exp_cx [int];
  logic [9:0]  exp_cy [int];
  bit          m_clr [1200];
  int          free_at = 0;
  logic [9:0]  m_cx = '0, m_cy = '0;
  logic [10:0] m_wa = '0;
  logic [2:0]  m_wd = '0;
  int          m_cnt = 0;

  always @(negedge clk) begin : compare
    int n, col, row, idx;
    bit e_wr, e_rej, was_full;
    logic [19:0] r;
    n = cyc;
    e_wr = 1'b0;
    e_rej = 1'b0;
    if (!reset_n) begin
      req_q.delete(); exp_q.delete(); exp_wr.delete(); exp_rej.delete();
      cnt_inc.delete(); exp_cx.delete(); exp_cy.delete();
      free_at = 0; m_cx = '0; m_cy = '0; m_wa = '0; m_wd = '0; m_cnt = 0;
    end else begin
      if (exp_cx.exists(n)) begin
        m_cx = exp_cx[n]; m_cy = exp_cy[n];
        exp_cx.delete(n); exp_cy.delete(n);
      end
      if (cnt_inc.exists(n)) begin
        if (m_cnt != 255) m_cnt++;
        cnt_inc.delete(n);
      end
      if (exp_wr.exists(n)) begin
        e_wr = 1'b1;
        exp_wr.delete(n);
        if (exp_q.size() > 0) m_wa = exp_q.pop_front();
        m_wd = CLEAR;
      end
      if (exp_rej.exists(n)) begin
        e_rej = 1'b1;
        exp_rej.delete(n);
      end
    end
    check("wr_en", 32'(wr_en), 32'(e_wr));
    check("destroyed", 32'(destroyed), 32'(e_wr));
    check("rejected", 32'(rejected), 32'(e_rej));
    check("wr_addr", 32'(wr_addr), 32'(m_wa));
    check("wr_data", 32'(wr_data), 32'(m_wd));
    check("chk_x", 32'(chk_x), 32'(m_cx));
    check("chk_y", 32'(chk_y), 32'(m_cy));
    check("destroy_count", 32'(destroy_count), 32'(m_cnt));
    check("req_ready", 32'(req_ready), 32'(req_q.size() < DEPTH));
    if (reset_n) begin
      was_full = (req_q.size() >= DEPTH);
      if (n >= free_at && req_q.size() > 0 && vblank) begin
        r   = req_q.pop_front();
        col = int'(r[9:0]) / 16;
        row = int'(r[19:10]) / 16;
        if (col >= 40 || row >= 30) begin
          exp_rej[n+1] = 1'b1;
          free_at = n + 1;
        end else begin
          idx = row * 40 + col;
          exp_cx[n+1] = 10'(col * 16);
          exp_cy[n+1] = 10'(row * 16);
          if (!m_clr[idx] && init_map[idx] == MATCH) begin
            m_clr[idx] = 1'b1;
            exp_wr[n+3] = 1'b1;
            exp_q.push_back(11'(idx));
            cnt_inc[n+4] = 1'b1;
            free_at = n + 4;
          end else begin
            exp_rej[n+2] = 1'b1;
            free_at = n + 3;
          end
        end
      end
      if (req_valid && !was_full) req_q.push_back({req_y, req_x});
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_tile(input int idx, input logic [2:0] t);
    init_map[idx] = t;
  endtask

  task automatic push(input int x, input int y, output int acc);
    bit ok;
    req_valid = 1'b1;
    req_x = 10'(x);
    req_y = 10'(y);
    acc = -1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      ok = req_ready;
      if (ok) acc = cyc;
      tick();
      if (ok) break;
    end
    req_valid = 1'b0;
    if (acc < 0) check("push_timeout", 32'd0, 32'd1);
  endtask

  // sel 0 waits for wr_en, sel 1 for rejected; returns at the negedge where it was seen
  task automatic wait_sig(input int sel, input int limit, input string nm, output int at);
    at = -1;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if ((sel == 0 && wr_en) || (sel == 1 && rejected)) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) check(nm, 32'd0, 32'd1);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1);
  end

  initial begin : stimulus
    int acc, at, a2;
    reset_n = 1'b0; req_valid = 1'b0; req_x = '0; req_y = '0; vblank = 1'b0;
    for (int i = 0; i < 1200; i++) init_map[i] = 3'd0;
    #2;
    check("rst_wr_en", 32'(wr_en), 32'd0);
    check("rst_ready", 32'(req_ready), 32'd1);
    check("rst_count", 32'(destroy_count), 32'd0);
    check("rst_chk_x", 32'(chk_x), 32'd0);
    check("rst_wr_addr", 32'(wr_addr), 32'd0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    tick();

    // single destroyable request
    set_tile(498, 3'd4);
    vblank = 1'b1;
    push(300, 200, acc);
    wait_sig(0, 10, "single_wr_timeout", at);
    check("single_latency", 32'(at - acc), 32'd4);
    check("single_addr", 32'(wr_addr), 32'd498);
    check("single_data", 32'(wr_data), 32'd0);
    check("single_destroyed", 32'(destroyed), 32'd1);
    check("single_chk_x", 32'(chk_x), 32'd288);
    check("single_chk_y", 32'(chk_y), 32'd192);
    tick();
    @(negedge clk);
    check("single_count", 32'(destroy_count), 32'd1);
    tick();

    // non-destroyable tile
    set_tile(499, 3'd1);
    push(310, 200, acc);
    wait_sig(1, 10, "nondestroy_timeout", at);
    check("nondestroy_latency", 32'(at - acc), 32'd3);
    check("nondestroy_no_wr", 32'(wr_en), 32'd0);
    repeat (3) tick();
    @(negedge clk);
    check("nondestroy_count", 32'(destroy_count), 32'd1);
    tick();

    // out of range
    push(650, 10, acc);
    wait_sig(1, 10, "oor_timeout", at);
    check("oor_latency", 32'(at - acc), 32'd2);
    check("oor_chk_x", 32'(chk_x), 32'd304);
    check("oor_chk_y", 32'(chk_y), 32'd192);
    tick();

    // duplicate request for one tile
    set_tile(500, 3'd4);
    push(320, 200, acc);
    push(320, 200, a2);
    repeat (12) tick();
    @(negedge clk);
    check("dup_count", 32'(destroy_count), 32'd2);
    tick();

    // backpressure with vblank low, then drain in order
    vblank = 1'b0;
    for (int k = 1; k <= 5; k++) set_tile(480 + k, 3'd4);
    for (int k = 1; k <= 4; k++) push(16 * k + 2, 195, acc);
    req_valid = 1'b1; req_x = 10'(16 * 5 + 2); req_y = 10'd195;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_ready_low", 32'(req_ready), 32'd0);
      tick();
    end
    vblank = 1'b1;
    push(16 * 5 + 2, 195, acc);
    repeat (25) tick();
    @(negedge clk);
    check("bp_count", 32'(destroy_count), 32'd7);
    tick();

    // vblank drops while a request is in LOOKUP
    vblank = 1'b0;
    for (int k = 6; k <= 8; k++) set_tile(480 + k, 3'd4);
    for (int k = 6; k <= 8; k++) push(16 * k + 1, 200, acc);
    vblank = 1'b1;
    tick();
    vblank = 1'b0;
    wait_sig(0, 6, "vb_inflight_timeout", at);
    tick();
    repeat (12) tick();
    @(negedge clk);
    check("vb_hold_count", 32'(destroy_count), 32'd8);
    tick();
    vblank = 1'b1;
    repeat (12) tick();
    vblank = 1'b0;
    @(negedge clk);
    check("vb_resume_count", 32'(destroy_count), 32'd10);
    tick();

    // reset with queued requests and the FSM in DECIDE
    for (int k = 9; k <= 12; k++) set_tile(480 + k, 3'd4);
    for (int k = 9; k <= 12; k++) push(16 * k + 3, 197, acc);
    vblank = 1'b1;
    tick();
    vblank = 1'b0;
    tick();
    reset_n = 1'b0;
    #1;
    check("rst_mid_wr_en", 32'(wr_en), 32'd0);
    check("rst_mid_rejected", 32'(rejected), 32'd0);
    check("rst_mid_ready", 32'(req_ready), 32'd1);
    check("rst_mid_count", 32'(destroy_count), 32'd0);
    check("rst_mid_chk_x", 32'(chk_x), 32'd0);
    check("rst_mid_wr_addr", 32'(wr_addr), 32'd0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    vblank = 1'b1;
    repeat (20) tick();
    @(negedge clk);
    check("rst_after_count", 32'(destroy_count), 32'd0);
    tick();

    // saturation of destroy_count
    for (int k = 0; k < 260; k++) set_tile(600 + k, 3'd4);
    for (int k = 0; k < 260; k++) push(((600 + k) % 40) * 16 + 3, ((600 + k) / 40) * 16 + 5, acc);
    repeat (40) tick();
    @(negedge clk);
    check("sat_count", 32'(destroy_count), 32'd255);
    check("sat_idle_wr_en", 32'(wr_en), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
